// File: rtl/prbs_block_gen.sv
// PRBS block source: BLOCK_W-bit blocks from a selectable Fibonacci LFSR
// over a valid/ready handshake, with seeding, run length, abort and error injection.
module prbs_block_gen #(
  parameter int          BLOCK_W = 257,
  parameter int          CNT_W   = 32,
  parameter logic [30:0] SEED    = 31'h1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [2:0]         mode,
  input  logic               seed_load,
  input  logic [30:0]        seed_in,
  input  logic [CNT_W-1:0]   num_blocks,
  input  logic               inj_err,
  input  logic               ready,
  output logic [BLOCK_W-1:0] data_out,
  output logic               data_valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   blk_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic [2:0]         mode_q;
  logic [30:0]        seed_q;
  logic [30:0]        lfsr_q;
  logic [CNT_W-1:0]   num_q;
  logic               inj_q;

  logic [2:0]         gen_mode;
  logic [4:0]         tap_n;
  logic [4:0]         tap_m;
  logic [30:0]        mask;
  logic [30:0]        seed_m;
  logic [30:0]        gen_s;
  logic [30:0]        gen_end;
  logic [BLOCK_W-1:0] gen_blk;
  logic [BLOCK_W-1:0] flip;

  logic               start_acc;
  logic               xfer;
  logic               last;
  logic               load;
  logic [CNT_W-1:0]   cnt_inc;

  // In IDLE the generator previews block 0 from the seed and live mode.
  always_comb begin
    gen_mode = (state == IDLE) ? mode : mode_q;
    case (gen_mode)
      3'd0:    begin tap_n = 5'd6;  tap_m = 5'd5;  mask = 31'h7f;       end
      3'd1:    begin tap_n = 5'd8;  tap_m = 5'd4;  mask = 31'h1ff;      end
      3'd2:    begin tap_n = 5'd14; tap_m = 5'd13; mask = 31'h7fff;     end
      3'd3:    begin tap_n = 5'd22; tap_m = 5'd17; mask = 31'h7fffff;   end
      default: begin tap_n = 5'd30; tap_m = 5'd27; mask = 31'h7fffffff; end
    endcase
    seed_m = seed_q & mask;
    if (seed_m == 31'h0) seed_m = 31'h1;
    gen_s = (state == IDLE) ? seed_m : lfsr_q;
  end

  always_comb begin
    logic [30:0] s;
    logic        fb;
    s       = gen_s;
    gen_blk = '0;
    for (int i = 0; i < BLOCK_W; i++) begin
      fb                   = s[tap_n] ^ s[tap_m];
      gen_blk[BLOCK_W-1-i] = fb;
      s                    = {s[29:0], fb};
    end
    gen_end = s;
  end

  assign flip      = {inj_q, {(BLOCK_W-1){1'b0}}};
  assign cnt_inc   = blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign start_acc = (state == IDLE) && start && !stop;
  assign xfer      = (state == RUN) && data_valid && ready;
  assign last      = (num_q != '0) && (cnt_inc == num_q);
  assign load      = start_acc || (xfer && !stop && !last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_acc)              state_nxt = RUN;
      RUN:  if (stop || (xfer && last)) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      done       <= 1'b0;
      blk_cnt    <= '0;
      mode_q     <= 3'd0;
      num_q      <= '0;
      seed_q     <= SEED;
      lfsr_q     <= 31'h0;
      inj_q      <= 1'b0;
    end else begin
      done <= xfer && last && !stop;
      if (state == IDLE && seed_load) seed_q <= seed_in;
      if (start_acc) begin
        mode_q  <= mode;
        num_q   <= num_blocks;
        blk_cnt <= '0;
      end else if (xfer) begin
        blk_cnt <= cnt_inc;
      end
      if (start_acc)
        data_valid <= 1'b1;
      else if (state == RUN && (stop || (xfer && last)))
        data_valid <= 1'b0;
      // A pulse landing on a load edge is kept for the following block.
      if (load) begin
        data_out <= gen_blk ^ flip;
        lfsr_q   <= gen_end;
        inj_q    <= inj_err;
      end else begin
        inj_q <= inj_q | inj_err;
      end
    end
  end

endmodule

// File: doc/prbs_block_gen.md
# prbs_block_gen

Parametrised pseudo-random block source for the AUI datapath test path. It generates consecutive BLOCK_W-bit blocks (257 by default, matching the transcoded block width) from a selectable PRBS polynomial and presents them on a valid/ready handshake. It supports seeding, bounded or free-running block counts, abort, and single-bit error injection. It feeds the scrambler/FEC blocks under test and is the reference stream for the downstream PRBS checker.

## Interface
- BLOCK_W, 257, bits per output block
- CNT_W, 32, width of block count/limit
- SEED, 31'h1, reset value of the seed register

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run (sampled in IDLE only)
- stop  in  1  abort the current run
- mode  in  3  polynomial: 0=PRBS7, 1=PRBS9, 2=PRBS15, 3=PRBS23, 4=PRBS31, 5-7 treated as PRBS31
- seed_load  in  1  load seed_in into the seed register (IDLE only)
- seed_in  in  31  seed value
- num_blocks  in  CNT_W  blocks per run; 0 = free-running
- inj_err  in  1  request a one-bit error in the next loaded block
- ready  in  1  sink accepts data_out
- data_out  out  BLOCK_W  current block; first-generated bit at MSB
- data_valid  out  1  data_out holds a valid block
- busy  out  1  FSM in RUN
- done  out  1  one-cycle pulse after the last block transfers
- blk_cnt  out  CNT_W  blocks transferred in the current or last run

## Operation
- Polynomials are x^n + x^m + 1, with (n,m) = (7,6), (9,5), (15,14), (23,18), (31,28).
- LFSR is 31 bits in Fibonacci form. One step: fb = s[n-1]^s[m-1]; s <= {s[29:0], fb}. The emitted bit is fb.
- One block = BLOCK_W steps, computed combinationally (unrolled). The first step's bit lands in data_out[BLOCK_W-1]. Consecutive blocks continue the sequence with no gap.
- Seed register resets to SEED. seed_load is honoured in IDLE only and ignored when busy.
- On an accepted start: mode is latched, and the LFSR is loaded with the seed masked to n bits. If the masked seed is 0, 1 is used instead (lock-up avoidance). mode and num_blocks changes during RUN are ignored.
- FSM states:
  - IDLE -> RUN on start && !stop.
  - RUN -> IDLE on stop, or on the transfer of block number num_blocks when num_blocks != 0.
- Transfer = data_valid && ready on a clock edge. On each transfer blk_cnt increments (wrapping at 2^CNT_W). If more blocks remain, the next block is loaded into data_out.
- data_out and data_valid are held stable while data_valid && !ready.
- inj_err sets a pending flag. The flag is applied to the next block loaded into data_out by inverting data_out[BLOCK_W-1], then cleared. The LFSR sequence is unaffected. Multiple pulses before application collapse into one. A flag set in IDLE applies to block 0.
- stop in RUN: the pending block is dropped, data_valid goes to 0, blk_cnt holds, no done pulse. stop together with start in IDLE: start is ignored.
- start during RUN is ignored.

## Timing
- Reset values: data_out=0, data_valid=0, busy=0, done=0, blk_cnt=0, FSM=IDLE, inject flag=0, seed register=SEED.
- start accepted at edge T: busy=1, data_valid=1, and block 0 is on data_out after T. blk_cnt is cleared at T.
- Transfer at edge k with blocks remaining: block k+1 is on data_out after k, and data_valid stays 1. Full throughput is one block per cycle with ready held high.
- Last transfer at edge k: after k, data_valid=0, busy=0, done=1 for one cycle, and blk_cnt=num_blocks (held until the next start).
- stop at edge k: after k, data_valid=0 and busy=0. If a transfer coincides with stop at the same edge, it counts in blk_cnt.
- rst mid-run: all outputs return to reset values asynchronously. The seed register also reverts to SEED.

## Test plan
- BLOCK_W=8, mode=0, seed=1, num_blocks=2, ready=1 -> block0 = 8'h06, block1 continues the sequence (matches bench model), done pulse one cycle after 2nd transfer, blk_cnt=2.
- Default BLOCK_W=257, mode=4, num_blocks=1000, random ready -> every block matches the software PRBS31 model, data_out stable while stalled, blk_cnt=1000, exactly one done.
- inj_err pulsed twice during one stall in free-run -> exactly the next loaded block differs from the model, only in its MSB, and later blocks are error-free.
- seed_load with seed_in=0, mode=2, start -> LFSR starts from 1; seed_load during RUN is ignored.
- stop while data_valid=1 and ready=0 at blk_cnt=5 -> after the edge data_valid=0, busy=0, no done, blk_cnt=5; start together with stop in IDLE -> stays IDLE.
- rst asserted mid-run with data_valid=1 -> all outputs 0 immediately; the next start uses SEED.
